// File: rtl/output_line_buffer_pkg.sv
// Shared constants and helpers for the egress ping-pong line buffer.
package output_line_buffer_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 3;

  // Width of a word counter for a line of m pixels (at least one bit).
  function automatic int word_cnt_w(input int m);
    if (m / LANES > 1) begin
      return $clog2(m / LANES);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/output_line_buffer_bank.sv
// One line bank: M/8 words of eight packed pixels, synchronous write,
// combinational lane-selected read.
module output_bank
  import output_line_buffer_pkg::*;
#(
  parameter int N = 24,
  parameter int M = 240
) (
  input  logic                         i_clk,
  input  logic                         we,
  input  logic [word_cnt_w(M)-1:0]     waddr,
  input  logic [LANES*N-1:0]           wdata,
  input  logic [word_cnt_w(M)-1:0]     raddr,
  input  logic [LANE_W-1:0]            rlane,
  output logic [N-1:0]                 rdata
);

  localparam int WORDS = M / LANES;

  logic [LANES*N-1:0] mem_r [WORDS];
  logic [LANES*N-1:0] word_s;

  // Word storage write port
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Lane 0 sits in the low bits and is the leftmost pixel
  always_comb begin
    word_s = mem_r[raddr];
    rdata  = word_s[int'(rlane)*N +: N];
  end

endmodule

// File: rtl/output_line_buffer.sv
// Ping-pong egress line buffer: 8-lane word writes, single-pixel valid/ready drain.
// Optional sticky drop flag o_overflow under OUTBUF_OVERFLOW_FLAG_EN.
module output_line_buffer
  import output_line_buffer_pkg::*;
#(
  parameter int N = 24,
  parameter int M = 240
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_data1,
  input  logic [N-1:0] i_data2,
  input  logic [N-1:0] i_data3,
  input  logic [N-1:0] i_data4,
  input  logic [N-1:0] i_data5,
  input  logic [N-1:0] i_data6,
  input  logic [N-1:0] i_data7,
  input  logic [N-1:0] i_data8,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_last
`ifdef OUTBUF_OVERFLOW_FLAG_EN
  , output logic       o_overflow
`endif
);

  localparam int WORDS = M / LANES;
  localparam int WCW   = word_cnt_w(M);
  localparam logic [WCW-1:0]    LAST_WORD = WCW'(WORDS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [1:0]         full_r;
  logic               wr_bank_r;
  logic [WCW-1:0]     wr_cnt_r;
  logic               rd_bank_r;
  logic [WCW-1:0]     rd_word_r;
  logic [LANE_W-1:0]  rd_lane_r;

  logic               ready_s;
  logic               valid_s;
  logic               accept_s;
  logic               fire_s;
  logic               wr_done_s;
  logic               rd_done_s;
  logic [1:0]         we_s;
  logic [1:0]         set_s;
  logic [1:0]         clr_s;
  logic [1:0]         full_nxt_s;
  logic [LANES*N-1:0] wr_word_s;
  logic [N-1:0]       rd_pix_s [2];

  assign wr_word_s = {i_data8, i_data7, i_data6, i_data5,
                      i_data4, i_data3, i_data2, i_data1};

  // Handshake decode and full-flag next state; the two completions always hit different banks
  always_comb begin
    ready_s    = !full_r[wr_bank_r] && !i_rst;
    valid_s    = full_r[rd_bank_r];
    accept_s   = i_valid && ready_s;
    fire_s     = valid_s && i_ready;
    wr_done_s  = accept_s && (wr_cnt_r == LAST_WORD);
    rd_done_s  = fire_s && (rd_word_r == LAST_WORD) && (rd_lane_r == LAST_LANE);
    we_s       = {accept_s && wr_bank_r, accept_s && !wr_bank_r};
    set_s      = {wr_done_s && wr_bank_r, wr_done_s && !wr_bank_r};
    clr_s      = {rd_done_s && rd_bank_r, rd_done_s && !rd_bank_r};
    full_nxt_s = (full_r | set_s) & ~clr_s;
  end

  // Output pixel mux, zero when nothing is presented
  always_comb begin
    o_ready = ready_s;
    o_valid = valid_s;
    o_last  = valid_s && (rd_word_r == LAST_WORD) && (rd_lane_r == LAST_LANE);
    if (valid_s) begin
      o_data = rd_pix_s[rd_bank_r];
    end else begin
      o_data = {N{1'b0}};
    end
  end

  // Write/read pointers and bank ownership
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      wr_cnt_r  <= {WCW{1'b0}};
      rd_bank_r <= 1'b0;
      rd_word_r <= {WCW{1'b0}};
      rd_lane_r <= {LANE_W{1'b0}};
    end else begin
      full_r <= full_nxt_s;
      if (accept_s) begin
        if (wr_done_s) begin
          wr_cnt_r  <= {WCW{1'b0}};
          wr_bank_r <= ~wr_bank_r;
        end else begin
          wr_cnt_r  <= wr_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
        end
      end
      if (fire_s) begin
        if (rd_lane_r == LAST_LANE) begin
          rd_lane_r <= {LANE_W{1'b0}};
          if (rd_word_r == LAST_WORD) begin
            rd_word_r <= {WCW{1'b0}};
            rd_bank_r <= ~rd_bank_r;
          end else begin
            rd_word_r <= rd_word_r + {{(WCW-1){1'b0}}, 1'b1};
          end
        end else begin
          rd_lane_r <= rd_lane_r + 3'd1;
        end
      end
    end
  end

`ifdef OUTBUF_OVERFLOW_FLAG_EN
  logic overflow_r;

  // Sticky record of any word offered while the buffer could not take it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow_r <= 1'b0;
    end else if (i_valid && !ready_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign o_overflow = overflow_r;
`endif

  output_bank #(.N(N), .M(M)) u_bank0 (
    .i_clk (i_clk),
    .we    (we_s[0]),
    .waddr (wr_cnt_r),
    .wdata (wr_word_s),
    .raddr (rd_word_r),
    .rlane (rd_lane_r),
    .rdata (rd_pix_s[0])
  );

  output_bank #(.N(N), .M(M)) u_bank1 (
    .i_clk (i_clk),
    .we    (we_s[1]),
    .waddr (wr_cnt_r),
    .wdata (wr_word_s),
    .raddr (rd_word_r),
    .rlane (rd_lane_r),
    .rdata (rd_pix_s[1])
  );

endmodule

// File: tb/tb_output_line_buffer.sv
// Directed self-checking bench for output_line_buffer (N=24, M=240);
// overflow-flag checks compile in with OUTBUF_OVERFLOW_FLAG_EN.
module tb_output_line_buffer;

  localparam int N = 24;
  localparam int M = 240;

  logic         clk;
  logic         i_rst;
  logic [N-1:0] d [8];
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] o_data;
  logic         o_valid;
  logic         i_ready;
  logic         o_last;
`ifdef OUTBUF_OVERFLOW_FLAG_EN
  logic         o_overflow;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  int pix_base = 0;
  int line_words = 0;
  int lasts_seen = 0;
  logic [N-1:0] exp_q [$];
  logic         last_q [$];
  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_data;
  logic         prev_last;
  logic         s_valid, s_ready, s_last;
  logic [N-1:0] s_data;

  output_line_buffer #(.N(N), .M(M)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_data1 (d[0]),
    .i_data2 (d[1]),
    .i_data3 (d[2]),
    .i_data4 (d[3]),
    .i_data5 (d[4]),
    .i_data6 (d[5]),
    .i_data7 (d[6]),
    .i_data8 (d[7]),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_last  (o_last)
`ifdef OUTBUF_OVERFLOW_FLAG_EN
    , .o_overflow (o_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs after the falling edge, sample 1ns later, score the pixel stream.
  task automatic cycle(input logic v, input logic r);
    @(negedge clk);
    i_valid = v;
    i_ready = r;
    for (int k = 0; k < 8; k++) d[k] = N'(pix_base + k);
    #1;
    s_valid = o_valid;
    s_ready = o_ready;
    s_last  = o_last;
    s_data  = o_data;
    if (i_rst) begin
      exp_q.delete();
      last_q.delete();
      line_words = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && o_valid) begin
        tests_run++;
        if (o_data !== prev_data || o_last !== prev_last) begin
          tests_failed++;
          $display("FAIL hold: got data %0d last %0b, required %0d last %0b",
                   o_data, o_last, prev_data, prev_last);
        end
      end
      if (!o_valid) begin
        tests_run++;
        if (o_data !== {N{1'b0}} || o_last !== 1'b0) begin
          tests_failed++;
          $display("FAIL idle: got data %0d last %0b, required 0 0", o_data, o_last);
        end
      end else if (r) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL spurious: got pixel %0d, required no pixel", o_data);
        end else begin
          if (o_data !== exp_q[0] || o_last !== last_q[0]) begin
            tests_failed++;
            $display("FAIL pixel: got %0d last %0b, required %0d last %0b",
                     o_data, o_last, exp_q[0], last_q[0]);
          end
          void'(exp_q.pop_front());
          void'(last_q.pop_front());
        end
        if (o_last) lasts_seen++;
      end
      prev_stall = o_valid && !r;
      prev_data  = o_data;
      prev_last  = o_last;
      if (v && o_ready) begin
        for (int k = 0; k < 8; k++) begin
          exp_q.push_back(N'(pix_base + k));
          last_q.push_back(line_words == 29 && k == 7);
        end
        line_words = (line_words == 29) ? 0 : line_words + 1;
        pix_base += 8;
      end
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cycle(1'b0, 1'b0);
    i_rst = 1'b0;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (exp_q.size() > 0 && k < bound) begin
      cycle(1'b0, 1'b1);
      k++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pixels left, required 0", exp_q.size());
    end
    cycle(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    tests_run++;
    if (s_ready !== 1'b0 || s_valid !== 1'b0 || s_data !== {N{1'b0}} || s_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL in_reset: got rdy %0b vld %0b data %0d last %0b, required 0 0 0 0",
               s_ready, s_valid, s_data, s_last);
    end
    i_rst = 1'b0;
    cycle(1'b0, 1'b0);
    tests_run++;
    if (s_ready !== 1'b1 || s_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset: got rdy %0b vld %0b, required 1 0", s_ready, s_valid);
    end
  endtask

  task automatic test_single_line();
    int l0;
    pix_base = 0;
    l0 = lasts_seen;
    for (int w = 0; w < 30; w++) cycle(1'b1, 1'b1);
    tests_run++;
    if (s_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_valid: got %0b, required 0", s_valid);
    end
    cycle(1'b0, 1'b1);
    tests_run++;
    if (s_valid !== 1'b1 || s_data !== 24'd0) begin
      tests_failed++;
      $display("FAIL first_pixel: got vld %0b data %0d, required 1 0", s_valid, s_data);
    end
    drain(300);
    tests_run++;
    if (lasts_seen - l0 != 1) begin
      tests_failed++;
      $display("FAIL single_last: got %0d, required 1", lasts_seen - l0);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    logic ev, er;
    for (int c = 0; c <= 750; c++) begin
      cycle(acc < 90, 1'b1);
      if ((acc < 90) && s_ready) acc++;
      ev = (c >= 30 && c < 750);
      tests_run++;
      if (s_valid !== ev) begin
        tests_failed++;
        $display("FAIL b2b_valid c=%0d: got %0b, required %0b", c, s_valid, ev);
      end
      if (c < 300) begin
        er = !(c >= 60 && c <= 269);
        tests_run++;
        if (s_ready !== er) begin
          tests_failed++;
          $display("FAIL b2b_ready c=%0d: got %0b, required %0b", c, s_ready, er);
        end
      end
    end
    drain(10);
  endtask

  task automatic test_simultaneous();
    logic v;
    for (int c = 0; c <= 750; c++) begin
      v = (c <= 58) || (c >= 269 && c <= 299);
      cycle(v, 1'b1);
      tests_run++;
      if (s_valid !== (c >= 30 && c < 750)) begin
        tests_failed++;
        $display("FAIL simul_valid c=%0d: got %0b", c, s_valid);
      end
      if (c == 269) begin
        tests_run++;
        if (s_ready !== 1'b1 || s_last !== 1'b1) begin
          tests_failed++;
          $display("FAIL simul_269: got rdy %0b last %0b, required 1 1", s_ready, s_last);
        end
      end
      if (c == 270 || c == 300) begin
        tests_run++;
        if (s_ready !== (c == 270)) begin
          tests_failed++;
          $display("FAIL simul_ready c=%0d: got %0b, required %0b", c, s_ready, c == 270);
        end
      end
    end
    drain(10);
  endtask

  task automatic test_stall();
    int l0;
    int k = 0;
    l0 = lasts_seen;
    for (int w = 0; w < 30; w++) cycle(1'b1, 1'b1);
    while (exp_q.size() > 0 && k < 600) begin
      cycle(1'b0, (k % 2) == 0);
      k++;
    end
    tests_run++;
    if (exp_q.size() != 0 || k != 479) begin
      tests_failed++;
      $display("FAIL stall_len: got %0d cycles %0d left, required 479 0", k, exp_q.size());
    end
    drain(10);
    tests_run++;
    if (lasts_seen - l0 != 1) begin
      tests_failed++;
      $display("FAIL stall_last: got %0d, required 1", lasts_seen - l0);
    end
  endtask

  task automatic test_reset_mid();
    pix_base = 1000;
    for (int w = 0; w < 30; w++) cycle(1'b1, 1'b1);
    for (int k = 0; k < 100; k++) cycle(k < 12, 1'b1);
    i_rst = 1'b1;
    cycle(1'b0, 1'b1);
    i_rst = 1'b0;
    cycle(1'b0, 1'b1);
    tests_run++;
    if (s_valid !== 1'b0 || s_last !== 1'b0 || s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset: got vld %0b last %0b rdy %0b, required 0 0 1",
               s_valid, s_last, s_ready);
    end
    pix_base = 5000;
    for (int w = 0; w < 30; w++) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    tests_run++;
    if (s_valid !== 1'b1 || s_data !== 24'd5000) begin
      tests_failed++;
      $display("FAIL fresh_line: got vld %0b data %0d, required 1 5000", s_valid, s_data);
    end
    drain(300);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int w = 0; w < 60; w++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    tests_run++;
    if (s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL both_full: got rdy %0b, required 0", s_ready);
    end
`ifdef OUTBUF_OVERFLOW_FLAG_EN
    tests_run++;
    if (o_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %0b, required 0", o_overflow);
    end
`endif
    pix_base = 9000;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
`ifdef OUTBUF_OVERFLOW_FLAG_EN
    tests_run++;
    if (o_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: got %0b, required 1", o_overflow);
    end
`endif
    drain(600);
`ifdef OUTBUF_OVERFLOW_FLAG_EN
    tests_run++;
    if (o_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got %0b, required 1", o_overflow);
    end
    do_reset();
    cycle(1'b0, 1'b1);
    tests_run++;
    if (o_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_reset: got %0b, required 0", o_overflow);
    end
`endif
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    for (int k = 0; k < 8; k++) d[k] = {N{1'b0}};
    test_reset();
    test_single_line();
    test_back_to_back();
    test_simultaneous();
    test_stall();
    test_reset_mid();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
